// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive buffer: port addresses, status bit layout
// and the FIFO entry format {ferr, perr, data[7:0]}.
package uart_rx_fifo_pkg;

  localparam logic [3:0] DATA_PORT   = 4'h0;
  localparam logic [3:0] STATUS_PORT = 4'h1;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_PERR   = 3;
  localparam int ST_FERR   = 4;

  localparam int ENTRY_W    = 10;
  localparam int ENTRY_PERR = 8;
  localparam int ENTRY_FERR = 9;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-engine strobe plus PicoBlaze port-read bus seen by the receive buffer.
interface uart_rx_fifo_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rx_ferr;
  logic [3:0] port_id;
  logic       read_strobe;
  logic [7:0] out_data;
  logic       interrupt;

  modport master (
    output rx_done, rx_data, rx_perr, rx_ferr, port_id, read_strobe,
    input  out_data, interrupt
  );

  modport slave (
    input  rx_done, rx_data, rx_perr, rx_ferr, port_id, read_strobe,
    output out_data, interrupt
  );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic synchronous FIFO core: storage, wrapping pointers and occupancy count.
// Push on full is accepted only when a pop happens in the same cycle.
import uart_rx_fifo_pkg::*;

module sync_fifo #(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rp];

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: queues completed frames with their error flags and exposes
// them to the PicoBlaze through a data port, a status port and a level interrupt.
import uart_rx_fifo_pkg::*;

module uart_rx_fifo #(
  parameter int         DEPTH       = 16,
  parameter int         AW          = 4,
  parameter logic [3:0] DATA_PORT   = uart_rx_fifo_pkg::DATA_PORT,
  parameter logic [3:0] STATUS_PORT = uart_rx_fifo_pkg::STATUS_PORT
) (
  input logic           CLK,
  input logic           RESET,
  uart_rx_fifo_if.slave bus
);

  logic               data_rd;
  logic               stat_rd;
  logic               push;
  logic               pop;
  logic               drop;
  logic               empty;
  logic               full;
  logic               ovf;
  logic               int_q;
  logic [AW:0]        count;
  logic [AW:0]        count_nxt;
  logic [ENTRY_W-1:0] head;
  logic [7:0]         status;

  assign data_rd = bus.read_strobe & (bus.port_id == DATA_PORT);
  assign stat_rd = bus.read_strobe & (bus.port_id == STATUS_PORT);
  assign pop     = data_rd & ~empty;
  assign push    = bus.rx_done & (~full | pop);
  assign drop    = bus.rx_done & full & ~pop;

  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.rx_ferr, bus.rx_perr, bus.rx_data}),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  // A drop in the same cycle as a status read keeps ovf set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf   <= 1'b0;
      int_q <= 1'b0;
    end else begin
      if (drop)         ovf <= 1'b1;
      else if (stat_rd) ovf <= 1'b0;
      int_q <= (count_nxt != '0);
    end
  end

  always_comb begin
    status              = '0;
    status[ST_NEMPTY]   = ~empty;
    status[ST_FULL]     = full;
    status[ST_OVF]      = ovf;
    status[ST_PERR]     = ~empty & head[ENTRY_PERR];
    status[ST_FERR]     = ~empty & head[ENTRY_FERR];
  end

  always_comb begin
    bus.out_data = 8'h00;
    if (bus.port_id == DATA_PORT) begin
      if (!empty) bus.out_data = head[7:0];
    end else if (bus.port_id == STATUS_PORT) begin
      bus.out_data = status;
    end
  end

  assign bus.interrupt = int_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [9:0] q[$];
  bit         m_ovf;
  bit         m_int;

  uart_rx_fifo_if bus ();

  uart_rx_fifo dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_out(input logic [3:0] pid);
    logic [7:0] r;
    bit ne;
    ne = (q.size() != 0);
    r  = 8'h00;
    if (pid == 4'h0) begin
      if (ne) r = q[0][7:0];
    end else if (pid == 4'h1) begin
      r = {3'b000, ne ? q[0][9] : 1'b0, ne ? q[0][8] : 1'b0,
           m_ovf, q.size() == DEPTH, ne};
    end
    return r;
  endfunction

  function automatic void m_clear();
    q.delete();
    m_ovf = 0;
    m_int = 0;
  endfunction

  task automatic idle();
    bus.rx_done     = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rx_perr     = 1'b0;
    bus.rx_ferr     = 1'b0;
    bus.read_strobe = 1'b0;
  endtask

  // One clock: drive, check combinational read and interrupt, clock, update model.
  task automatic cycle(input logic rd, input logic [7:0] d, input logic pe, input logic fe,
                       input logic rs, input logic [3:0] pid);
    bit emp, ful, p, u;
    bus.rx_done     = rd;
    bus.rx_data     = d;
    bus.rx_perr     = pe;
    bus.rx_ferr     = fe;
    bus.read_strobe = rs;
    bus.port_id     = pid;
    @(negedge CLK);
    chk("out_data", bus.out_data, m_out(pid));
    chk("interrupt", {7'b0, bus.interrupt}, {7'b0, m_int});
    @(posedge CLK);
    emp = (q.size() == 0);
    ful = (q.size() == DEPTH);
    p   = rs && (pid == 4'h0) && !emp;
    u   = rd && (!ful || p);
    if (rd && ful && !p)            m_ovf = 1;
    else if (rs && (pid == 4'h1))   m_ovf = 0;
    if (p) void'(q.pop_front());
    if (u) q.push_back({fe, pe, d});
    m_int = (q.size() != 0);
    #1;
    idle();
  endtask

  task automatic push(input logic [7:0] d, input logic pe = 1'b0, input logic fe = 1'b0);
    cycle(1'b1, d, pe, fe, 1'b0, 4'h2);
  endtask

  task automatic pop_rd();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0);
  endtask

  // Look at a port without strobing it; no clock edge passes.
  task automatic peek(input string tag, input logic [3:0] pid, input logic [7:0] exp);
    bus.read_strobe = 1'b0;
    bus.rx_done     = 1'b0;
    bus.port_id     = pid;
    #1;
    chk(tag, bus.out_data, exp);
  endtask

  task automatic hit_reset();
    #2 RESET = 1'b1;
    #1;
    m_clear();
    peek("rst_status", 4'h1, 8'h00);
    peek("rst_data", 4'h0, 8'h00);
    chk("rst_int", {7'b0, bus.interrupt}, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    idle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    bus.port_id = 4'h1;
    m_clear();
    #12;
    peek("rst_status", 4'h1, 8'h00);
    peek("rst_data", 4'h0, 8'h00);
    chk("rst_int", {7'b0, bus.interrupt}, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // single byte round trip
    push(8'hA5);
    peek("a5_status", 4'h1, 8'h01);
    chk("a5_int", {7'b0, bus.interrupt}, 8'h01);
    peek("a5_data", 4'h0, 8'hA5);
    pop_rd();
    peek("a5_empty", 4'h1, 8'h00);
    chk("a5_int_drop", {7'b0, bus.interrupt}, 8'h00);

    // fill, overflow, clear ovf, simultaneous push/pop while full, drain
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    peek("full_status", 4'h1, 8'h03);
    push(8'hFF);
    peek("ovf_status", 4'h1, 8'h07);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h1);
    peek("ovf_clear", 4'h1, 8'h03);
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 4'h0);
    peek("full_pp_status", 4'h1, 8'h03);
    peek("full_pp_head", 4'h0, 8'h01);
    for (int i = 0; i < DEPTH; i++) pop_rd();
    peek("drained", 4'h1, 8'h00);

    // error flags travel with their byte
    push(8'h3C, 1'b1, 1'b0);
    push(8'h7E, 1'b0, 1'b1);
    peek("perr_status", 4'h1, 8'h09);
    peek("perr_data", 4'h0, 8'h3C);
    pop_rd();
    peek("ferr_status", 4'h1, 8'h11);
    peek("ferr_data", 4'h0, 8'h7E);
    pop_rd();

    // reads while empty, push with read while empty
    pop_rd();
    peek("empty_data", 4'h0, 8'h00);
    cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 4'h0);
    peek("empty_pp_status", 4'h1, 8'h01);
    peek("empty_pp_data", 4'h0, 8'h42);
    pop_rd();
    peek("other_port", 4'h7, 8'h00);

    // pointer wrap with interleaved pairs
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom));
      pop_rd();
    end

    // randomized phases: fill-heavy then drain-heavy, with a mid-burst reset
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic       rd, rs, pe, fe;
        logic [3:0] pid;
        rd  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 30));
        rs  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 75));
        pe  = ($urandom_range(0, 3) == 0);
        fe  = ($urandom_range(0, 3) == 0);
        pid = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                          : 4'($urandom_range(0, 1));
        cycle(rd, 8'($urandom), pe, fe, rs, pid);
      end
      if (ph == 1) begin
        for (int i = 0; i < 6; i++) push(8'($urandom));
        bus.rx_done = 1'b1;
        bus.rx_data = 8'hEE;
        hit_reset();
        push(8'h99);
        peek("post_rst_data", 4'h0, 8'h99);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the UART receive engine and the PicoBlaze port-read bus.
- Captures each byte the receive engine completes, together with its parity and framing error flags, into a small FIFO.
- Presents FIFO data and a status byte to the processor through port_id / read_strobe decoding.
- Drives a level interrupt while data is pending, so the processor can drain bursts without losing bytes.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- AW, 4, pointer width; equals log2(DEPTH).
- DATA_PORT, 4'h0, port_id value that reads and pops the FIFO head.
- STATUS_PORT, 4'h1, port_id value that reads the status byte.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- rx_done  input  1  one-cycle strobe from the receive engine: a frame has completed.
- rx_data  input  8  received byte; valid when rx_done=1. In 7-bit mode bit7 is already 0.
- rx_perr  input  1  parity error for this frame; valid with rx_done.
- rx_ferr  input  1  framing (stop bit) error for this frame; valid with rx_done.
- port_id  input  4  processor port address.
- read_strobe  input  1  processor read qualifier, one cycle per read.
- out_data  output  8  read data for the processor input mux.
- interrupt  output  1  high while the FIFO is non-empty.

Behaviour:
- Storage: DEPTH x 10-bit entries {ferr, perr, data[7:0]}.
- State: write pointer wp[AW-1:0], read pointer rp[AW-1:0], count[AW:0] (0..DEPTH), sticky overflow bit ovf.
- Reset: wp=0, rp=0, count=0, ovf=0, interrupt=0, out_data=8'h00. Storage contents are don't-care.
- empty = (count==0); full = (count==DEPTH).
- pop = read_strobe & (port_id==DATA_PORT) & !empty.
- push = rx_done & (!full | pop).
- Push: mem[wp] <= {rx_ferr, rx_perr, rx_data}; wp increments and wraps from DEPTH-1 to 0 naturally.
- Pop: rp increments with the same wrap.
- Count update:
  - push & !pop: count +1.
  - pop & !push: count -1.
  - both or neither: unchanged.
- Full with simultaneous push and pop: both occur, count stays at DEPTH, no overflow.
- Empty with rx_done: push only. Pop is suppressed; a pop in the same cycle is ignored.
- Overflow: rx_done & full & !pop drops the byte and sets ovf. The FIFO is unchanged.
- Status read (read_strobe & port_id==STATUS_PORT) clears ovf at the clock edge. If an overflow occurs in the same cycle, set wins and ovf stays 1.
- out_data is combinational from port_id, valid in the same cycle as read_strobe:
  - port_id==DATA_PORT: mem[rp][7:0] if non-empty, else 8'h00.
  - port_id==STATUS_PORT: {3'b000, head_ferr, head_perr, ovf, full, !empty}. Head flags read 0 when empty.
  - any other port_id: 8'h00.
- Latency: a byte pushed at edge N is visible on the data port and in status bit0 from cycle N+1.
- interrupt: registered, = !empty after each edge. It drops in the cycle after the last pop, unless a push coincides with that pop.
- Reads on other port_ids, or read_strobe=0, have no side effects.
- RESET asserted mid-operation: all state clears immediately (asynchronous); in-flight rx_done is lost.

Decomposition:
- Shared UART package holds:
  - port address constants DATA_PORT / STATUS_PORT;
  - status bit indices (ST_NEMPTY=0, ST_FULL=1, ST_OVF=2, ST_PERR=3, ST_FERR=4);
  - FIFO entry width constant (10).
- One natural sub-module: sync_fifo, the generic pointer/count/storage core with push/pop/full/empty.
- uart_rx_fifo wraps sync_fifo with port decode, overflow sticky, status assembly and interrupt.

Test Plan:
- Reset, then push 8'hA5 (no errors) -> next cycle interrupt=1, status=8'h01; data read returns 8'hA5 -> status=8'h00, interrupt=0 one cycle later.
- Push 16 bytes 8'h00..8'h0F -> status=8'h03 (full, non-empty); 17th push 8'hFF -> dropped, status=8'h07; status read clears ovf -> next status=8'h03; 16 data reads return 8'h00..8'h0F in order.
- Full FIFO, push 8'h55 in the same cycle as a data read -> read returns the oldest byte, count stays 16, ovf=0, 8'h55 appears last.
- Push 8'h3C with rx_perr=1, then 8'h7E with rx_ferr=1 -> status=8'h09 and data 8'h3C; after pop, status=8'h11 and data 8'h7E.
- Data read while empty -> out_data=8'h00, pointers unchanged; push plus data read in the same cycle while empty -> no pop, count=1.
- Wrap-around: 40 interleaved push/pop pairs -> data order preserved across pointer wrap. Assert RESET mid-burst -> status=8'h00 and interrupt=0 immediately after reset.
